// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment patterns for BCD 0..9; bit0 (dp) is off in every entry.
    localparam logic [7:0] SEG_PATTERN [0:9] = '{
        8'h81, 8'hF3, 8'h49, 8'h61, 8'h33,
        8'h25, 8'h05, 8'hF1, 8'h01, 8'h21
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low segment decode with a dark override.
module seg_decode
    import seg_pkg::*;
(
    input  digit_t      bcd_i,
    input  logic        dark_i,
    input  logic        dp_i,
    output logic [7:0]  seg_c
);

    // Non-decimal codes render dark, same as an explicit dark request.
    always_comb begin
        seg_c = SEG_BLANK;
        if (!dark_i && (bcd_i <= digit_t'(9))) begin
            seg_c = {SEG_PATTERN[bcd_i][7:1], ~dp_i};
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Parametrised multiplexed 7-segment scan driver with frame-coherent snapshot,
// leading-zero suppression, blanking, blinking and decimal points.
// Optional build macro GHOST_BLANK_EN adds one dark cycle at the start of each slot.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 50,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      CP,
    input  logic                      reset,
    input  logic                      EN,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      lz_sup,
    output logic [7:0]                segO,
    output logic [NUM_DIGITS-1:0]     bitO,
    output logic                      frame_start
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         slot_q, slot_d;
    logic [IW-1:0]         cur_q, cur_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    logic                  active_q, active_d;
    logic [DW-1:0]         snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0] snap_blink_q, snap_blink_d;
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic                  snap_lz_q, snap_lz_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] bit_q, bit_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  frame_tick;
    digit_t                dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] supp;
    logic [NUM_DIGITS-1:0] sel_bit;
    logic                  run;
    logic                  dark;
    logic [7:0]            dec_seg;

    assign tick       = EN && (presc_q == PW'(SCAN_DIV - 1));
    // slot_q names the slot shown at the next tick, so the first tick after reset opens a frame on digit 0.
    assign frame_tick = tick && (slot_q == '0);

    // Scan timing, blink phase and frame snapshot next-state.
    always_comb begin
        presc_d      = presc_q;
        slot_d       = slot_q;
        cur_d        = cur_q;
        fcnt_d       = fcnt_q;
        phase_d      = phase_q;
        active_d     = active_q | tick;
        snap_dig_d   = snap_dig_q;
        snap_blank_d = snap_blank_q;
        snap_blink_d = snap_blink_q;
        snap_dp_d    = snap_dp_q;
        snap_lz_d    = snap_lz_q;
        if (EN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            cur_d  = slot_q;
            slot_d = (slot_q == IW'(NUM_DIGITS - 1)) ? '0 : slot_q + IW'(1);
        end
        if (frame_tick) begin
            snap_dig_d   = digits_in;
            snap_blank_d = blank_mask;
            snap_blink_d = blink_mask;
            snap_dp_d    = dp_mask;
            snap_lz_d    = lz_sup;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + FW'(1);
            end
        end
    end

    // Digit unpack, leading-zero run from the top digit, and one-hot-low select.
    always_comb begin
        run     = 1'b1;
        supp    = '0;
        sel_bit = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dig[i]     = snap_dig_d[4*i +: 4];
            sel_bit[i] = (IW'(i) != cur_d);
        end
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run     = run & (dig[i] == digit_t'(0));
            supp[i] = snap_lz_d & run & (i != 0);
        end
        dark = snap_blank_d[cur_d] | (snap_blink_d[cur_d] & phase_d) | supp[cur_d];
    end

    seg_decode u_decode (
        .bcd_i  (dig[cur_d]),
        .dark_i (dark),
        .dp_i   (snap_dp_d[cur_d]),
        .seg_c  (dec_seg)
    );

    // Output next-state: dark unless scanning, and dark on the tick edge when dead-time is built in.
    always_comb begin
        seg_d = SEG_BLANK;
        bit_d = '1;
        fs_d  = frame_tick;
        if (EN && (tick || active_q) && !(GHOST && tick)) begin
            seg_d = dec_seg;
            bit_d = sel_bit;
        end
    end

    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            slot_q       <= '0;
            cur_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            active_q     <= 1'b0;
            snap_dig_q   <= '0;
            snap_blank_q <= '0;
            snap_blink_q <= '0;
            snap_dp_q    <= '0;
            snap_lz_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            bit_q        <= '1;
            fs_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            cur_q        <= cur_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            active_q     <= active_d;
            snap_dig_q   <= snap_dig_d;
            snap_blank_q <= snap_blank_d;
            snap_blink_q <= snap_blink_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            seg_q        <= seg_d;
            bit_q        <= bit_d;
            fs_q         <= fs_d;
        end
    end

    assign segO        = seg_q;
    assign bitO        = bit_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (8 digits, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;

    logic        CP;
    logic        reset;
    logic        EN;
    logic [31:0] digits_in;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  dp_mask;
    logic        lz_sup;
    logic [7:0]  segO;
    logic [7:0]  bitO;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .NUM_DIGITS   (8),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CP          (CP),
        .reset       (reset),
        .EN          (EN),
        .digits_in   (digits_in),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .lz_sup      (lz_sup),
        .segO        (segO),
        .bitO        (bitO),
        .frame_start (frame_start)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic step(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at the negedge just after the tick edge that opens slot 0; leaves at the same point one frame later.
    task automatic check_frame(input string tag, input logic [7:0] exp [8]);
        for (int k = 0; k < 8; k++) begin
            chk8($sformatf("%s_s%0d_fs", tag, k), {7'd0, frame_start}, (k == 0) ? 8'h01 : 8'h00);
`ifdef GHOST_BLANK_EN
            chk8($sformatf("%s_s%0d_dead", tag, k), bitO, 8'hFF);
`else
            chk8($sformatf("%s_s%0d_bit0", tag, k), bitO, 8'(~(8'h01 << k)));
`endif
            step(1);
            chk8($sformatf("%s_s%0d_bit", tag, k), bitO, 8'(~(8'h01 << k)));
            chk8($sformatf("%s_s%0d_seg", tag, k), segO, exp[k]);
            step(3);
        end
    endtask

    // Release reset at a negedge; the first tick lands on the fourth edge and opens slot 0.
    task automatic release_reset(input string tag);
        reset = 1'b0;
        step(3);
        chk8({tag, "_pre_bit"}, bitO, 8'hFF);
        chk8({tag, "_pre_seg"}, segO, 8'hFF);
        step(1);
    endtask

    logic [7:0] e [8];

    initial begin
        reset      = 1'b1;
        EN         = 1'b1;
        digits_in  = 32'h12345678;
        blank_mask = 8'h00;
        blink_mask = 8'h00;
        dp_mask    = 8'h00;
        lz_sup     = 1'b0;
        step(2);
        chk8("rst_seg", segO, 8'hFF);
        chk8("rst_bit", bitO, 8'hFF);
        chk8("rst_fs", {7'd0, frame_start}, 8'h00);

        release_reset("r1");
        e = '{8'h01, 8'hF1, 8'h05, 8'h25, 8'h33, 8'h61, 8'h49, 8'hF3};
        check_frame("f12345678", e);

        // Async reset in the middle of slot 5.
        step(21);
        #2 reset = 1'b1;
        #1;
        chk8("midrst_seg", segO, 8'hFF);
        chk8("midrst_bit", bitO, 8'hFF);
        chk8("midrst_fs", {7'd0, frame_start}, 8'h00);
        digits_in = 32'h00000305;
        lz_sup    = 1'b1;
        @(negedge CP);
        release_reset("r2");
        e = '{8'h25, 8'h81, 8'h61, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_frame("lz305", e);

        // Input change after the frame has been captured stays invisible for this frame.
        digits_in = 32'h00000000;
        check_frame("lzhold", e);
        e = '{8'h81, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_frame("lzzero", e);

        digits_in  = 32'h0C000921;
        dp_mask    = 8'h04;
        blank_mask = 8'h10;
        lz_sup     = 1'b0;
        step(32);
        e = '{8'hF3, 8'h49, 8'h20, 8'h81, 8'hFF, 8'h81, 8'hFF, 8'h81};
        check_frame("dpblank", e);

        digits_in  = 32'h12345678;
        dp_mask    = 8'h00;
        blank_mask = 8'h00;
        blink_mask = 8'h03;
        step(32);
        e = '{8'hFF, 8'hFF, 8'h05, 8'h25, 8'h33, 8'h61, 8'h49, 8'hF3};
        check_frame("blink7", e);
        e = '{8'h01, 8'hF1, 8'h05, 8'h25, 8'h33, 8'h61, 8'h49, 8'hF3};
        check_frame("blink8", e);
        check_frame("blink9", e);
        e = '{8'hFF, 8'hFF, 8'h05, 8'h25, 8'h33, 8'h61, 8'h49, 8'hF3};
        check_frame("blink10", e);

        // EN low for 10 cycles in the middle of slot 3.
        step(13);
        EN = 1'b0;
        step(1);
        chk8("en_off_bit", bitO, 8'hFF);
        chk8("en_off_seg", segO, 8'hFF);
        step(9);
        chk8("en_off9_bit", bitO, 8'hFF);
        chk8("en_off9_seg", segO, 8'hFF);
        chk8("en_off9_fs", {7'd0, frame_start}, 8'h00);
        EN = 1'b1;
        step(1);
        chk8("en_resume_bit", bitO, 8'hF7);
        chk8("en_resume_seg", segO, 8'h25);
        step(2);
`ifdef GHOST_BLANK_EN
        chk8("en_next_dead", bitO, 8'hFF);
`else
        chk8("en_next_bit0", bitO, 8'hEF);
`endif
        step(1);
        chk8("en_next_bit", bitO, 8'hEF);
        chk8("en_next_seg", segO, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
